// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, instruction encodings and helpers for the load/store unit
package lsu_pkg;

    localparam int XLEN   = 32;
    localparam int TYPE_W = 5;

    localparam logic [TYPE_W-1:0] INST_REG      = 5'd0;
    localparam logic [TYPE_W-1:0] INST_LOAD_B   = 5'd1;
    localparam logic [TYPE_W-1:0] INST_LOAD_H   = 5'd2;
    localparam logic [TYPE_W-1:0] INST_LOAD_W   = 5'd3;
    localparam logic [TYPE_W-1:0] INST_LOAD_BU  = 5'd4;
    localparam logic [TYPE_W-1:0] INST_LOAD_HU  = 5'd5;
    localparam logic [TYPE_W-1:0] INST_STORE_B  = 5'd6;
    localparam logic [TYPE_W-1:0] INST_STORE_H  = 5'd7;
    localparam logic [TYPE_W-1:0] INST_STORE_W  = 5'd8;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    function automatic logic is_load(input logic [TYPE_W-1:0] t);
        return (t == INST_LOAD_B) || (t == INST_LOAD_H) || (t == INST_LOAD_W) ||
               (t == INST_LOAD_BU) || (t == INST_LOAD_HU);
    endfunction

    function automatic logic is_store(input logic [TYPE_W-1:0] t);
        return (t == INST_STORE_B) || (t == INST_STORE_H) || (t == INST_STORE_W);
    endfunction

    // Halfwords need an even address, words a 4-byte-aligned one; bytes never fault.
    function automatic logic is_misaligned(input logic [TYPE_W-1:0] t, input logic [1:0] lo);
        if ((t == INST_LOAD_H) || (t == INST_LOAD_HU) || (t == INST_STORE_H))
            return lo[0];
        else if ((t == INST_LOAD_W) || (t == INST_STORE_W))
            return (lo != 2'b00);
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// rtl/lsu_extract.sv - selects the addressed byte/half of a read word and extends it
module lsu_extract
    import lsu_pkg::*;
#(
    parameter int REG_W = XLEN
) (
    input  logic [TYPE_W-1:0] inst_type,
    input  logic [1:0]        addr_lo,
    input  logic [REG_W-1:0]  mem_rdata,
    output logic [REG_W-1:0]  rdata
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Lane select by low address bits, then sign or zero extension by load kind.
    always_comb begin
        byte_val = mem_rdata[{addr_lo, 3'b000} +: 8];
        half_val = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
        case (inst_type)
            INST_LOAD_B:  rdata = {{(REG_W-8){byte_val[7]}}, byte_val};
            INST_LOAD_BU: rdata = {{(REG_W-8){1'b0}}, byte_val};
            INST_LOAD_H:  rdata = {{(REG_W-16){half_val[15]}}, half_val};
            INST_LOAD_HU: rdata = {{(REG_W-16){1'b0}}, half_val};
            INST_LOAD_W:  rdata = mem_rdata;
            default:      rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one aligned bus transaction per memory instruction
module lsu
    import lsu_pkg::*;
#(
    parameter int REG_W       = XLEN,
    parameter int INST_TYPE_W = TYPE_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reqValid,
    output logic                   respValid,
    input  logic [INST_TYPE_W-1:0] inst_type,
    input  logic [REG_W-1:0]       lsu_addr,
    input  logic [REG_W-1:0]       lsu_wdata,
    output logic [REG_W-1:0]       lsu_rdata,
    output logic                   lsu_misaligned,
    output logic                   mem_reqValid,
    input  logic                   mem_reqReady,
    output logic                   mem_wen,
    output logic [REG_W-1:0]       mem_addr,
    output logic [REG_W-1:0]       mem_wdata,
    output logic [3:0]             mem_wstrb,
    input  logic                   mem_respValid,
    input  logic [REG_W-1:0]       mem_rdata
);

    state_t                 state;
    state_t                 state_nxt;
    logic [INST_TYPE_W-1:0] type_q;
    logic [REG_W-1:0]       addr_q;
    logic [REG_W-1:0]       wdata_q;
    logic                   misal_q;
    logic [REG_W-1:0]       rdata_q;
    logic [REG_W-1:0]       ext_rdata;
    logic                   accept;
    logic                   pass_through;

    assign accept       = (state == IDLE) && reqValid && (is_load(inst_type) || is_store(inst_type));
    assign pass_through = (state == IDLE) && reqValid && !(is_load(inst_type) || is_store(inst_type));

    lsu_extract #(.REG_W(REG_W)) u_extract (
        .inst_type (type_q),
        .addr_lo   (addr_q[1:0]),
        .mem_rdata (mem_rdata),
        .rdata     (ext_rdata)
    );

    // State register; reset abandons any bus transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: faulted accesses skip the bus and answer straight away.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = is_misaligned(inst_type, lsu_addr[1:0]) ? RESP : ADDR;
            ADDR: if (mem_reqReady) state_nxt = DATA;
            DATA: if (mem_respValid) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request is captured at accept so bus outputs stay stable while waiting for ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q  <= INST_REG;
            addr_q  <= '0;
            wdata_q <= '0;
            misal_q <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            type_q  <= inst_type;
            addr_q  <= lsu_addr;
            wdata_q <= lsu_wdata;
            misal_q <= is_misaligned(inst_type, lsu_addr[1:0]);
            rdata_q <= '0;
        end else if ((state == DATA) && mem_respValid) begin
            rdata_q <= is_load(type_q) ? ext_rdata : '0;
        end
    end

    // Outputs: handshake from state, store lanes replicated and strobed from the latched request.
    always_comb begin
        mem_reqValid   = (state == ADDR);
        respValid      = (state == RESP) || pass_through;
        lsu_misaligned = (state == RESP) && misal_q;
        lsu_rdata      = pass_through ? '0 : rdata_q;
        mem_addr       = {addr_q[REG_W-1:2], 2'b00};
        mem_wen        = is_store(type_q);
        mem_wdata      = '0;
        mem_wstrb      = 4'b0000;
        case (type_q)
            INST_STORE_B: begin
                mem_wdata = {(REG_W/8){wdata_q[7:0]}};
                mem_wstrb = STRB_B << addr_q[1:0];
            end
            INST_STORE_H: begin
                mem_wdata = {(REG_W/16){wdata_q[15:0]}};
                mem_wstrb = STRB_H << addr_q[1:0];
            end
            INST_STORE_W: begin
                mem_wdata = wdata_q;
                mem_wstrb = STRB_W;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for the load/store unit
module tb_lsu;
    import lsu_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              reqValid;
    logic              respValid;
    logic [TYPE_W-1:0] inst_type;
    logic [31:0]       lsu_addr;
    logic [31:0]       lsu_wdata;
    logic [31:0]       lsu_rdata;
    logic              lsu_misaligned;
    logic              mem_reqValid;
    logic              mem_reqReady;
    logic              mem_wen;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_respValid;
    logic [31:0]       mem_rdata;

    logic [TYPE_W-1:0] ext_type;
    logic [1:0]        ext_lo;
    logic [31:0]       ext_rd;
    logic [31:0]       ext_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [TYPE_W-1:0] typ;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [31:0]       rdata;
        logic [31:0]       e_rdata;
        logic [31:0]       e_wdata;
        logic [3:0]        e_wstrb;
        logic              e_mis;
        int                d;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    lsu dut (
        .clk            (clk),
        .reset          (reset),
        .reqValid       (reqValid),
        .respValid      (respValid),
        .inst_type      (inst_type),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_rdata      (lsu_rdata),
        .lsu_misaligned (lsu_misaligned),
        .mem_reqValid   (mem_reqValid),
        .mem_reqReady   (mem_reqReady),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_respValid  (mem_respValid),
        .mem_rdata      (mem_rdata)
    );

    lsu_extract u_ext (
        .inst_type (ext_type),
        .addr_lo   (ext_lo),
        .mem_rdata (ext_rd),
        .rdata     (ext_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int idx);
        exp_t e;
        check1($sformatf("sb_nonempty[%0d]", idx), sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("lsu_rdata[%0d]", idx), lsu_rdata, e.rdata);
            check1($sformatf("lsu_misaligned[%0d]", idx), lsu_misaligned, e.mis);
        end
    endtask

    task automatic garble_inputs;
        reqValid  = 1'b0;
        inst_type = INST_STORE_W;
        lsu_addr  = 32'hFFFF_FFFF;
        lsu_wdata = 32'h0F0F_0F0F;
    endtask

    task automatic run(input vec_t v, input int idx);
        exp_t e;
        logic [31:0] e_addr;
        e_addr = {v.addr[31:2], 2'b00};
        @(negedge clk);
        reqValid  = 1'b1;
        inst_type = v.typ;
        lsu_addr  = v.addr;
        lsu_wdata = v.wdata;
        e.rdata   = v.e_rdata;
        e.mis     = v.e_mis;
        sb.push_back(e);
        if (v.typ == INST_REG) begin
            #1;
            check1($sformatf("nonmem_resp[%0d]", idx), respValid, 1'b1);
            check1($sformatf("nonmem_bus[%0d]", idx), mem_reqValid, 1'b0);
            if (respValid) sb_pop(idx);
            reqValid  = 1'b0;
            inst_type = INST_REG;
        end else begin
            @(negedge clk);
            if (v.e_mis) begin
                check1($sformatf("mis_resp_t1[%0d]", idx), respValid, 1'b1);
                check1($sformatf("mis_no_bus[%0d]", idx), mem_reqValid, 1'b0);
                if (respValid) sb_pop(idx);
                garble_inputs();
                @(negedge clk);
                check1($sformatf("mis_resp_one[%0d]", idx), respValid, 1'b0);
            end else begin
                check1($sformatf("req_valid[%0d]", idx), mem_reqValid, 1'b1);
                check($sformatf("mem_addr[%0d]", idx), mem_addr, e_addr);
                check1($sformatf("mem_wen[%0d]", idx), mem_wen, v.e_wstrb != 4'b0000);
                check($sformatf("mem_wstrb[%0d]", idx), {28'b0, mem_wstrb}, {28'b0, v.e_wstrb});
                if (v.e_wstrb != 4'b0000) check($sformatf("mem_wdata[%0d]", idx), mem_wdata, v.e_wdata);
                check1($sformatf("early_resp[%0d]", idx), respValid, 1'b0);
                garble_inputs();
                mem_reqReady = (v.d == 0);
                for (int i = 0; i < v.d; i++) begin
                    mem_respValid = 1'b1;
                    mem_rdata     = 32'hDEAD_DEAD;
                    @(negedge clk);
                    check1($sformatf("hold_valid[%0d.%0d]", idx, i), mem_reqValid, 1'b1);
                    check($sformatf("hold_addr[%0d.%0d]", idx, i), mem_addr, e_addr);
                    check($sformatf("hold_wstrb[%0d.%0d]", idx, i), {28'b0, mem_wstrb}, {28'b0, v.e_wstrb});
                end
                mem_respValid = 1'b0;
                mem_reqReady  = 1'b1;
                @(negedge clk);
                check1($sformatf("drop_valid[%0d]", idx), mem_reqValid, 1'b0);
                check1($sformatf("data_resp[%0d]", idx), respValid, 1'b0);
                mem_reqReady  = 1'b0;
                mem_respValid = 1'b1;
                mem_rdata     = v.rdata;
                @(negedge clk);
                check1($sformatf("resp_t3[%0d]", idx), respValid, 1'b1);
                if (respValid) sb_pop(idx);
                mem_respValid = 1'b0;
                mem_rdata     = 32'h0;
                @(negedge clk);
                check1($sformatf("resp_one[%0d]", idx), respValid, 1'b0);
                check($sformatf("rdata_hold[%0d]", idx), lsu_rdata, v.e_rdata);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset = 1'b1; reqValid = 1'b0; inst_type = INST_REG; lsu_addr = 0; lsu_wdata = 0;
        mem_reqReady = 1'b0; mem_respValid = 1'b0; mem_rdata = 0;
        ext_type = INST_REG; ext_lo = 0; ext_rd = 0;

        vecs.push_back('{INST_LOAD_B,  32'h1003, 32'h0,         32'h80FF_1234, 32'hFFFF_FF80, 32'h0,         4'b0000, 1'b0, 0});
        vecs.push_back('{INST_REG,     32'h1234, 32'h5555,      32'h0,         32'h0,         32'h0,         4'b0000, 1'b0, 0});
        vecs.push_back('{INST_LOAD_HU, 32'h2002, 32'h0,         32'h9ABC_0000, 32'h0000_9ABC, 32'h0,         4'b0000, 1'b0, 3});
        vecs.push_back('{INST_STORE_B, 32'h3001, 32'h1234_56A5, 32'h0,         32'h0,         32'hA5A5_A5A5, 4'b0010, 1'b0, 0});
        vecs.push_back('{INST_LOAD_W,  32'h4002, 32'h0,         32'h0,         32'h0,         32'h0,         4'b0000, 1'b1, 0});
        vecs.push_back('{INST_LOAD_H,  32'h0010, 32'h0,         32'h1234_F00D, 32'hFFFF_F00D, 32'h0,         4'b0000, 1'b0, 1});
        vecs.push_back('{INST_LOAD_BU, 32'h0021, 32'h0,         32'h0000_8000, 32'h0000_0080, 32'h0,         4'b0000, 1'b0, 0});
        vecs.push_back('{INST_STORE_H, 32'h0032, 32'hDEAD_BEEF, 32'h0,         32'h0,         32'hBEEF_BEEF, 4'b1100, 1'b0, 2});
        vecs.push_back('{INST_STORE_W, 32'h0040, 32'hCAFE_F00D, 32'h0,         32'h0,         32'hCAFE_F00D, 4'b1111, 1'b0, 0});
        vecs.push_back('{INST_LOAD_H,  32'h0051, 32'h0,         32'h0,         32'h0,         32'h0,         4'b0000, 1'b1, 0});
        vecs.push_back('{INST_STORE_W, 32'h0062, 32'h1111_2222, 32'h0,         32'h0,         32'h0,         4'b0000, 1'b1, 0});
        vecs.push_back('{INST_STORE_H, 32'h0073, 32'h3333_4444, 32'h0,         32'h0,         32'h0,         4'b0000, 1'b1, 0});
        vecs.push_back('{INST_STORE_B, 32'h0083, 32'h0000_003C, 32'h0,         32'h0,         32'h3C3C_3C3C, 4'b1000, 1'b0, 1});
        vecs.push_back('{INST_LOAD_W,  32'h0090, 32'h0,         32'h8765_4321, 32'h8765_4321, 32'h0,         4'b0000, 1'b0, 0});
        vecs.push_back('{INST_LOAD_HU, 32'h00A1, 32'h0,         32'h0,         32'h0,         32'h0,         4'b0000, 1'b1, 0});
        vecs.push_back('{INST_LOAD_B,  32'h00B2, 32'h0,         32'h007F_0000, 32'h0000_007F, 32'h0,         4'b0000, 1'b0, 0});
        vecs.push_back('{INST_LOAD_H,  32'h00C2, 32'h0,         32'h8001_0000, 32'hFFFF_8001, 32'h0,         4'b0000, 1'b0, 0});

        repeat (2) @(negedge clk);
        check1("rst_respValid", respValid, 1'b0);
        check1("rst_mem_reqValid", mem_reqValid, 1'b0);
        check1("rst_mem_wen", mem_wen, 1'b0);
        check1("rst_misaligned", lsu_misaligned, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_lsu_rdata", lsu_rdata, 32'h0);
        check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) run(vecs[i], i);

        // Standalone extractor over the aligned loads of the table.
        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.typ != INST_REG && v.e_wstrb == 4'b0000 && !v.e_mis) begin
                ext_type = v.typ;
                ext_lo   = v.addr[1:0];
                ext_rd   = v.rdata;
                #1;
                check($sformatf("extract[%0d]", i), ext_out, v.e_rdata);
            end
        end

        // Reset while waiting for the read response, then a stale response.
        @(negedge clk);
        reqValid = 1'b1; inst_type = INST_LOAD_W; lsu_addr = 32'h5000;
        @(negedge clk);
        garble_inputs();
        check1("rstseq_req_valid", mem_reqValid, 1'b1);
        mem_reqReady = 1'b1;
        @(negedge clk);
        mem_reqReady = 1'b0;
        reset = 1'b1;
        #1;
        check1("rstseq_valid_drop", mem_reqValid, 1'b0);
        check1("rstseq_no_resp", respValid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        inst_type = INST_LOAD_W;
        mem_respValid = 1'b1;
        mem_rdata = 32'h1111_1111;
        @(negedge clk);
        check1("rstseq_stale_resp", respValid, 1'b0);
        check1("rstseq_stale_bus", mem_reqValid, 1'b0);
        mem_respValid = 1'b0;
        @(negedge clk);
        check1("rstseq_stale_resp2", respValid, 1'b0);
        run('{INST_LOAD_W, 32'h5004, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0, 4'b0000, 1'b0, 0}, 100);

        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit. Target of the EXU memory request: receives `lsu_addr`, `lsu_wdata` and the instruction type, and returns `lsu_rdata`.
- Converts each load/store into a single word-aligned transaction on the data-memory bus. Handles byte-lane steering, write strobes, load sign/zero extension and misalignment detection.
- Uses the same `reqValid`/`respValid` handshake as the other pipeline stages.

Parameters:
- REG_W, 32, data/address width (matches REG_W_END+1)
- INST_TYPE_W, INST_TYPE_END+1, width of inst_type encoding (inst_defines.vh)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- reqValid  input  1  EXU presents an instruction this cycle
- respValid  output  1  instruction completed; lsu_rdata/lsu_misaligned valid
- inst_type  input  INST_TYPE_W  INST_LOAD_B/H/W/BU/HU, INST_STORE_B/H/W; anything else is non-memory
- lsu_addr  input  REG_W  byte address
- lsu_wdata  input  REG_W  store data, right-aligned
- lsu_rdata  output  REG_W  extended load result
- lsu_misaligned  output  1  access faulted on alignment
- mem_reqValid  output  1  bus request
- mem_reqReady  input  1  bus accepts request
- mem_wen  output  1  1 = write
- mem_addr  output  REG_W  {lsu_addr[31:2],2'b00}
- mem_wdata  output  REG_W  lane-replicated store data
- mem_wstrb  output  4  byte enables
- mem_respValid  input  1  bus response (read data or write ack)
- mem_rdata  input  REG_W  read word

Behaviour:
- Reset (async, immediate): state IDLE. Cleared outputs: respValid, mem_reqValid, mem_wen, lsu_misaligned = 0; mem_addr, mem_wdata, lsu_rdata = 0; mem_wstrb = 4'b0000.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - Non-memory inst_type: respValid = reqValid combinationally (0-cycle); lsu_rdata = 0.
  - Memory inst with reqValid: latch inst_type, addr, wdata. Later input changes are ignored until return to IDLE.
  - If misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0): go to RESP with misaligned flag and no bus traffic.
  - Otherwise: go to ADDR.
- ADDR:
  - mem_reqValid=1; mem_addr, mem_wen, mem_wdata and mem_wstrb are stable until mem_reqReady.
  - On mem_reqReady: go to DATA. mem_reqValid drops the following cycle.
  - mem_respValid in ADDR is ignored.
- DATA:
  - Wait for mem_respValid.
  - On mem_respValid: capture extended read data (loads) or 0 (stores); go to RESP.
- RESP:
  - respValid=1 for exactly one cycle; lsu_misaligned=1 only for faulted accesses. Then go to IDLE.
  - lsu_rdata holds until the next memory accept.
- Minimum latency, accept at cycle T: mem_reqValid at T+1; response at T+2; respValid at T+3. Misaligned accesses: respValid at T+1.
- Store steering:
  - SB: wdata={4{b}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata as-is, wstrb=4'b1111.
  - Loads: wstrb=4'b0000, mem_wen=0.
- Load extraction: byte = mem_rdata[8*addr[1:0]+:8]; half = mem_rdata[16*addr[1]+:16].
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: unchanged.
- Reset mid-transaction: FSM returns to IDLE asynchronously and mem_reqValid deasserts. A stale mem_respValid arriving afterwards is ignored in IDLE.
- reqValid while not IDLE: ignored; the EXU must not issue until respValid.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, ADDR, DATA, RESP}
  - strobe constants STRB_B=4'b0001, STRB_H=4'b0011, STRB_W=4'b1111
  - helper predicates is_load/is_store over inst_type
- Sub-module lsu_extract (combinational): inst_type, addr[1:0], mem_rdata -> extended rdata. It is instantiated once and tested standalone.

Test Plan:
- LOAD_B, addr=0x1003, mem_rdata=0x80FF_1234, ready/resp immediate -> mem_addr=0x1000, wstrb=0000, lsu_rdata=0xFFFF_FF80, respValid at T+3.
- LOAD_HU, addr=0x2002, mem_rdata=0x9ABC_0000, mem_reqReady held low 3 cycles -> mem_reqValid and mem_addr=0x2000 stable throughout; lsu_rdata=0x0000_9ABC.
- STORE_B, addr=0x3001, wdata=0x1234_56A5 -> mem_wen=1, mem_wdata=0xA5A5_A5A5, wstrb=0010; respValid after write ack.
- LOAD_W, addr=0x4002 -> no mem_reqValid; respValid and lsu_misaligned high at T+1; lsu_rdata=0.
- INST_REG with reqValid=1 -> respValid=1 same cycle, no bus activity.
- reset asserted in DATA, then mem_respValid pulse -> mem_reqValid=0 immediately, no respValid, next LOAD_W completes normally.
